// File: rtl/uart_pkg.sv
// Shared types and helpers for the counter-based UART transmitter.
package uart_pkg;

  localparam int unsigned DataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned bit_rate);
    return (clk_hz + bit_rate / 2) / bit_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses tick_o for one cycle when the count reaches Div-1.
module uart_baud_gen #(
  parameter int unsigned Div = 1250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cnt.sv
// 8N1 UART transmitter, one byte per START pulse; bit timing from a clock-cycle counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit(s).
module uart_tx_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned BIT_RATE  = 9600,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [DataW-1:0] DATA,
  output logic             TX,
  output logic             BUSY
);

  localparam int unsigned Div = calc_div(CLK_HZ, BIT_RATE);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  if (Div < 2) begin : g_div_chk
    $error("uart_tx_cnt: CLK_HZ/BIT_RATE must give at least 2 clocks per bit");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_cnt: STOP_BITS must be 1 or 2");
  end

  uart_state_e      state_q, state_d;
  logic [DataW-1:0] shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Counter is held at zero while idle so the start bit is exactly Div cycles.
  uart_baud_gen #(
    .Div (Div)
  ) u_baud_gen (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (state_q == StIdle),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d    = StStart;
          shift_d    = DATA;
          idx_d      = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d      = ^DATA;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q == 3'(DataW - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (stop_idx_q == LastStop) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_cnt.sv
// Self-checking bench for uart_tx_cnt: table of bytes plus hand-written corner sequences.
module tb_uart_tx_cnt;

  localparam int unsigned DIV     = 10;
  localparam int unsigned DIV_DEF = 1250;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, tx, busy;
  logic [7:0] data;
  logic       rst_def, start_def, tx_def, busy_def;
  logic [7:0] data_def;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int gap_last = 0;
  logic abort = 1'b0;
  logic [11:0] slot_bits;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cnt #(
    .CLK_HZ    (1_000_000),
    .BIT_RATE  (100_000),
    .STOP_BITS (1)
  ) u_dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .DATA  (data),
    .TX    (tx),
    .BUSY  (busy)
  );

  uart_tx_cnt u_dut_def (
    .CLK   (clk),
    .RST   (rst_def),
    .START (start_def),
    .DATA  (data_def),
    .TX    (tx_def),
    .BUSY  (busy_def)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: compares every TX cycle against the model frame of the queued byte.
  initial begin
    int cyc, idle, frame_err;
    logic in_frame, have_exp;
    logic [11:0] exp_frame;
    vec_t e;
    cyc = 0; idle = 1000; frame_err = 0; in_frame = 1'b0; have_exp = 1'b0;
    exp_frame = '1;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1; cyc = 0; frame_err = 0; gap_last = idle;
          slot_bits = '1;
          if (exp_q.size() == 0) begin
            have_exp = 1'b0;
            check("unexpected_frame", 1, 0);
          end else begin
            have_exp = 1'b1;
            e = exp_q[0];
            exp_frame = '1;
            exp_frame[0] = 1'b0;
            exp_frame[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
            exp_frame[9] = e.par;
`endif
          end
        end
        if (have_exp && cyc / DIV < NB && tx !== exp_frame[cyc/DIV]) frame_err++;
        if (cyc % DIV == DIV / 2 && cyc / DIV < 12) slot_bits[cyc/DIV] = tx;
        cyc++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (abort) begin
            abort = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else if (have_exp) begin
            e = exp_q.pop_front();
            check("busy_len", cyc, NB * DIV);
            check("frame_tx_errs", frame_err, 0);
            check("rx_data", slot_bits[8:1], e.data);
`ifdef UART_TX_PARITY_EN
            check("rx_parity", slot_bits[9], e.par);
`endif
          end
          frames_done++;
          idle = 0;
        end
        idle++;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames_done < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("frame_timeout", frames_done >= n, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p);
    vec_t v;
    int f0;
    v.data = d; v.par = p; f0 = frames_done;
    @(negedge clk);
    start = 1'b1; data = d;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    wait_frames(f0 + 1, NB * DIV + 20);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int f0, n, blen, slen, bad;
    logic seen_one;
    logic [9:0] exp41;

    tbl[0] = '{8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b0};
    tbl[2] = '{8'h07, 1'b1};
    tbl[3] = '{8'h80, 1'b1};
    tbl[4] = '{8'hA5, 1'b0};
    tbl[5] = '{8'h3C, 1'b0};
    tbl[6] = '{8'h01, 1'b1};

    rst = 1'b1; start = 1'b0; data = '0;
    rst_def = 1'b1; start_def = 1'b0; data_def = '0;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; rst_def = 1'b0;
    @(negedge clk);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);

    // Single byte 0x41: start bit appears one cycle after START.
    f0 = frames_done;
    v.data = 8'h41; v.par = 1'b0;
    start = 1'b1; data = 8'h41;
    exp_q.push_back(v);
    check("pre_accept_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_tx", tx, 0);
    wait_frames(f0 + 1, NB * DIV + 20);
`ifdef UART_TX_PARITY_EN
    exp41 = 10'b0010000010;
`else
    exp41 = 10'b1010000010;
`endif
    check("slots_0x41", slot_bits[9:0], exp41);

    // START while busy is ignored.
    f0 = frames_done;
    v.data = 8'h55; v.par = 1'b0;
    @(negedge clk);
    start = 1'b1; data = 8'h55;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    start = 1'b1; data = 8'hAA;
    @(negedge clk);
    start = 1'b0; data = 8'h00;
    check("ignore_busy_high", busy, 1);
    wait_frames(f0 + 1, NB * DIV + 20);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("ignore_no_second_frame", bad, 0);
    check("ignore_queue_empty", exp_q.size(), 0);

    // Back-to-back with START held: one idle cycle between frames.
    f0 = frames_done;
    v.data = 8'h40; v.par = 1'b1;
    start = 1'b1; data = 8'h40;
    exp_q.push_back(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 5);
    data = 8'h41;
    v.data = 8'h41; v.par = 1'b0;
    exp_q.push_back(v);
    n = 0;
    while (frames_done < f0 + 1 && n < NB * DIV + 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_gap", gap_last, 1);
    wait_frames(f0 + 2, 2 * NB * DIV + 40);

    // Mid-frame reset aborts, then a clean frame follows.
    v.data = 8'h00; v.par = 1'b0;
    @(negedge clk);
    start = 1'b1; data = 8'h00;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    rst = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    send_byte(8'h5A, 1'b0);

    // Reset and START together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; data = 8'hFF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_tx", tx, 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("rst_start_no_frame", bad, 0);

    // Table of bytes.
    for (int i = 0; i < 7; i++) send_byte(tbl[i].data, tbl[i].par);
    check("final_queue_empty", exp_q.size(), 0);

    // Default parameters: 1250 clocks per bit.
    @(negedge clk);
    start_def = 1'b1; data_def = 8'h07;
    @(negedge clk);
    start_def = 1'b0;
    blen = 0; slen = 0; seen_one = 1'b0;
    for (int i = 0; i < 20000 && busy_def === 1'b1; i++) begin
      blen++;
      if (!seen_one && tx_def === 1'b0) slen++;
      else seen_one = 1'b1;
      @(negedge clk);
    end
    check("def_start_len", slen, DIV_DEF);
    check("def_busy_len", blen, NB * DIV_DEF);
    check("def_idle_tx", tx_def, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
